// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch responder: state encoding,
// error codes and the response payload carried back to the core.
package ifu_pkg;

    localparam logic [31:0] BASE_ADDR_DEF = 32'h0000_3000;
    localparam int unsigned DEPTH_DEF     = 1024;
    localparam int unsigned TIMEOUT_DEF   = 16;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE = 2'b10;
    localparam logic [1:0] ERR_TMO   = 2'b11;

    localparam logic [31:0] NOP_INS = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MEM   = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } ifu_state_e;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic [1:0]  err;
    } ifu_resp_t;

    function automatic logic is_misaligned(input logic [31:0] pc);
        return |pc[1:0];
    endfunction

endpackage

// File: rtl/ifu_timeout_ctr.sv
// Cycle counter bounding how long an IM read may stay outstanding; expired_c is
// high during the last permitted cycle so the FSM can give up on that edge.
module ifu_timeout_ctr #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic clr,
    input  logic clear,
    input  logic en,
    output logic expired_c
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired_c = (cnt_q == CNT_W'(LIMIT - 1));

    // Saturates once expired so a stalled caller never sees it wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en && !expired_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_fetch_resp.sv
// Fetch responder: takes next-PC requests, reads the word from instruction memory
// over a variable-latency handshake and returns {ins, pc, err}, with flush support.
module instr_fetch_resp
    import ifu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter int unsigned ADDR_W    = $clog2(DEPTH),
    parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req_valid,
    input  logic [31:0]       req_pc,
    output logic              req_ready,
    input  logic              flush,
    output logic              resp_valid,
    output logic [31:0]       resp_ins,
    output logic [31:0]       resp_pc,
    output logic [1:0]        resp_err,
    input  logic              resp_ready,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam logic [31:0] IM_BYTES = 32'(4 * DEPTH);

    ifu_state_e        state_q, state_d;
    ifu_resp_t         resp_q, resp_d;
    logic              resp_valid_q, resp_valid_d;
    logic              mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              tmr_clear, tmr_en, tmr_expired;

    logic [31:0]       pc_off;
    logic              misaligned;
    logic              in_range;

    // Range check compares before subtracting so a pc below BASE_ADDR cannot wrap in.
    assign pc_off     = req_pc - BASE_ADDR;
    assign misaligned = is_misaligned(req_pc);
    assign in_range   = (req_pc >= BASE_ADDR) && (pc_off < IM_BYTES);

    assign req_ready  = (state_q == IDLE) && !flush;

    ifu_timeout_ctr #(
        .LIMIT(TIMEOUT)
    ) u_tmr (
        .clk      (clk),
        .clr      (clr),
        .clear    (tmr_clear),
        .en       (tmr_en),
        .expired_c(tmr_expired)
    );

    always_comb begin
        state_d      = state_q;
        resp_d       = resp_q;
        resp_valid_d = resp_valid_q;
        mem_rd_d     = mem_rd_q;
        mem_addr_d   = mem_addr_q;
        tmr_clear    = 1'b0;
        tmr_en       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    resp_d.pc = req_pc;
                    if (misaligned) begin
                        resp_d.ins   = NOP_INS;
                        resp_d.err   = ERR_ALIGN;
                        resp_valid_d = 1'b1;
                        state_d      = RESP;
                    end else if (!in_range) begin
                        resp_d.ins   = NOP_INS;
                        resp_d.err   = ERR_RANGE;
                        resp_valid_d = 1'b1;
                        state_d      = RESP;
                    end else begin
                        mem_rd_d   = 1'b1;
                        mem_addr_d = pc_off[ADDR_W+1:2];
                        tmr_clear  = 1'b1;
                        state_d    = MEM;
                    end
                end
            end
            MEM: begin
                tmr_en = 1'b1;
                if (flush) begin
                    // The read is already on the bus; finish it silently.
                    if (mem_ack || tmr_expired) begin
                        mem_rd_d = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        state_d  = DRAIN;
                    end
                end else if (mem_ack) begin
                    resp_d.ins   = mem_rdata;
                    resp_d.err   = ERR_OK;
                    resp_valid_d = 1'b1;
                    mem_rd_d     = 1'b0;
                    state_d      = RESP;
                end else if (tmr_expired) begin
                    resp_d.ins   = NOP_INS;
                    resp_d.err   = ERR_TMO;
                    resp_valid_d = 1'b1;
                    mem_rd_d     = 1'b0;
                    state_d      = RESP;
                end
            end
            DRAIN: begin
                tmr_en = 1'b1;
                if (mem_ack || tmr_expired) begin
                    mem_rd_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            RESP: begin
                if (flush || resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q      <= IDLE;
            resp_q       <= '0;
            resp_valid_q <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            resp_q       <= resp_d;
            resp_valid_q <= resp_valid_d;
            mem_rd_q     <= mem_rd_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_ins   = resp_q.ins;
    assign resp_pc    = resp_q.pc;
    assign resp_err   = resp_q.err;
    assign mem_rd     = mem_rd_q;
    assign mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_instr_fetch_resp.sv
// Self-checking bench for instr_fetch_resp: directed boundary/flush/reset scenarios
// plus randomized fetches checked against a behavioural fetch model.
module tb_instr_fetch_resp;

    localparam logic [31:0] BASE   = 32'h0000_3000;
    localparam longint      BASE_L = 64'h3000;
    localparam int          DEPTH  = 1024;
    localparam int          TMO    = 16;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        req_valid = 1'b0;
    logic [31:0] req_pc = 32'h0;
    logic        req_ready;
    logic        flush = 1'b0;
    logic        resp_valid;
    logic [31:0] resp_ins;
    logic [31:0] resp_pc;
    logic [1:0]  resp_err;
    logic        resp_ready = 1'b0;
    logic        mem_rd;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] im [0:DEPTH-1];

    always #5 clk = ~clk;

    instr_fetch_resp #(
        .BASE_ADDR(BASE),
        .DEPTH    (DEPTH),
        .ADDR_W   (10),
        .TIMEOUT  (TMO)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .req_valid (req_valid),
        .req_pc    (req_pc),
        .req_ready (req_ready),
        .flush     (flush),
        .resp_valid(resp_valid),
        .resp_ins  (resp_ins),
        .resp_pc   (resp_pc),
        .resp_err  (resp_err),
        .resp_ready(resp_ready),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    // Expected outcome of one fetch whose IM answers `lat` cycles after accept (0 = never).
    function automatic void ref_fetch(input logic [31:0] pc, input int lat,
                                      output logic [1:0] err, output logic [31:0] ins,
                                      output logic [9:0] addr, output int rd);
        longint p;
        p    = {32'h0, pc};
        addr = 10'((pc - BASE) >> 2);
        ins  = 32'h0;
        rd   = 0;
        if (pc[1:0] != 2'b00) err = 2'b01;
        else if (p < BASE_L || p >= BASE_L + 4 * DEPTH) err = 2'b10;
        else if (lat >= 1 && lat <= TMO) begin
            err = 2'b00;
            ins = im[addr];
            rd  = lat;
        end else begin
            err = 2'b11;
            rd  = TMO;
        end
    endfunction

    // Full request/response transaction; starts and ends just after a falling edge.
    task automatic run_fetch(input logic [31:0] pc, input int lat, input int stall);
        logic [1:0]  e_err;
        logic [31:0] e_ins;
        logic [9:0]  e_addr;
        int          e_rd;
        int          rd_seen;
        int          cyc;
        ref_fetch(pc, lat, e_err, e_ins, e_addr, e_rd);
        rd_seen = 0;
        cyc = 1;
        req_valid = 1'b1;
        req_pc = pc;
        #1;
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_ready pc=%h got=%b exp=1", pc, req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_pc = $urandom;
        while (resp_valid !== 1'b1 && cyc <= TMO + 3) begin
            if (mem_rd === 1'b1) begin
                rd_seen++;
                n_tests++;
                if (mem_addr !== e_addr) begin
                    n_fail++;
                    $display("FAIL mem_addr pc=%h got=%0d exp=%0d", pc, mem_addr, e_addr);
                end
            end
            mem_ack = (cyc == lat);
            mem_rdata = (cyc == lat) ? im[e_addr] : $urandom;
            @(negedge clk);
            mem_ack = 1'b0;
            cyc++;
        end
        n_tests++;
        if (resp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL resp_timeout pc=%h got resp_valid=%b exp=1", pc, resp_valid);
        end
        n_tests++;
        if (rd_seen != e_rd) begin
            n_fail++;
            $display("FAIL mem_rd_cycles pc=%h lat=%0d got=%0d exp=%0d", pc, lat, rd_seen, e_rd);
        end
        for (int s = 0; s <= stall; s++) begin
            if (s > 0) @(negedge clk);
            n_tests++;
            if ({resp_valid, req_ready, mem_rd, resp_ins, resp_pc, resp_err} !==
                {1'b1, 1'b0, 1'b0, e_ins, pc, e_err}) begin
                n_fail++;
                $display("FAIL resp pc=%h cyc=%0d got v=%b rdy=%b rd=%b ins=%h pc=%h err=%b exp ins=%h err=%b",
                         pc, s, resp_valid, req_ready, mem_rd, resp_ins, resp_pc, resp_err, e_ins, e_err);
            end
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        n_tests++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL handshake_done pc=%h got v=%b rdy=%b exp v=0 rdy=1", pc, resp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        #2 clr = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({req_ready, resp_valid, resp_ins, resp_pc, resp_err, mem_rd, mem_addr} !==
            {1'b1, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 10'h0}) begin
            n_fail++;
            $display("FAIL reset_state got rdy=%b v=%b ins=%h pc=%h err=%b rd=%b addr=%0d exp 1/0/0/0/0/0/0",
                     req_ready, resp_valid, resp_ins, resp_pc, resp_err, mem_rd, mem_addr);
        end
        clr = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        im[0] = 32'h3C01_1234;
        run_fetch(32'h0000_3000, 1, 0);
    endtask

    task automatic test_errors();
        run_fetch(32'h0000_3002, 1, 0);
        run_fetch(32'h0000_2FFE, 1, 0);
        run_fetch(32'h0000_2FFC, 1, 0);
        run_fetch(32'h0000_4000, 1, 0);
        run_fetch(32'h0000_3FFC, 2, 0);
        run_fetch(32'h0000_0000, 1, 0);
        run_fetch(32'hFFFF_FFFC, 1, 0);
    endtask

    task automatic test_timeout();
        run_fetch(32'h0000_3100, 0, 0);
        run_fetch(32'h0000_3104, TMO, 0);
        mem_ack = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_ack = 1'b0;
        n_tests++;
        if ({mem_rd, resp_valid, req_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL late_ack got rd=%b v=%b rdy=%b exp 0/0/1", mem_rd, resp_valid, req_ready);
        end
    endtask

    task automatic test_flush();
        req_valid = 1'b1;
        req_pc = BASE + 32'h10;
        @(negedge clk);
        req_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if ({resp_valid, mem_rd, req_ready} !== 3'b010) begin
                n_fail++;
                $display("FAIL drain k=%0d got v=%b rd=%b rdy=%b exp 0/1/0", k, resp_valid, mem_rd, req_ready);
            end
            if (k == 2) mem_ack = 1'b1;
            @(negedge clk);
        end
        mem_ack = 1'b0;
        n_tests++;
        if ({resp_valid, mem_rd, req_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL drain_end got v=%b rd=%b rdy=%b exp 0/0/1", resp_valid, mem_rd, req_ready);
        end
        @(negedge clk);
        n_tests++;
        if (resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_no_resp got v=%b exp 0", resp_valid);
        end
        // Flush while a response is waiting.
        req_valid = 1'b1;
        req_pc = BASE + 32'h1;
        @(negedge clk);
        req_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        n_tests++;
        if (resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_resp got v=%b exp 0", resp_valid);
        end
        flush = 1'b0;
        #1;
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_resp_ready got=%b exp=1", req_ready);
        end
        // Flush while idle blocks acceptance.
        req_valid = 1'b1;
        req_pc = BASE + 32'h1;
        flush = 1'b1;
        #1;
        n_tests++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle_ready got=%b exp=0", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        flush = 1'b0;
        n_tests++;
        if ({resp_valid, mem_rd} !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_idle_accept got v=%b rd=%b exp 0/0", resp_valid, mem_rd);
        end
    endtask

    task automatic test_stall_reset();
        run_fetch(BASE + 32'h20, 3, 5);
        req_valid = 1'b1;
        req_pc = BASE + 32'h8;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (mem_rd !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_rd got=%b exp=1", mem_rd);
        end
        #2 clr = 1'b0;
        #1;
        n_tests++;
        if ({mem_rd, resp_valid, req_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL async_reset got rd=%b v=%b rdy=%b exp 0/0/1", mem_rd, resp_valid, req_ready);
        end
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        run_fetch(BASE + 32'h8, 1, 0);
    endtask

    task automatic test_random();
        logic [31:0] pc;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0, 1: pc = BASE + 4 * $urandom_range(0, DEPTH - 1);
                2:    pc = (BASE + 4 * $urandom_range(0, DEPTH - 1)) | 32'($urandom_range(1, 3));
                3:    pc = BASE - 4 * $urandom_range(1, 8);
                4:    pc = BASE + 4 * DEPTH + 4 * $urandom_range(0, 8);
                default: pc = $urandom;
            endcase
            run_fetch(pc, $urandom_range(0, TMO + 2), $urandom_range(0, 3));
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) im[i] = $urandom;
        test_reset();
        test_basic();
        test_errors();
        test_timeout();
        test_flush();
        test_stall_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

endmodule
